// File: rtl/csa_pkg.sv
// Shared constants and FSM state type for the carry-save resolver.
package csa_pkg;

    localparam int CSA_BITS   = 48;
    localparam int CSA_CHUNK  = 16;
    localparam int CSA_NCHUNK = CSA_BITS / CSA_CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CHUNK-bit adder with carry in/out; one slice of the resolver.
module csa_chunk_add #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    // Widen by one bit so the carry out falls into the MSB.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(cin_i);

endmodule

// File: rtl/csa_resolver.sv
// Carry-save to binary resolver: adds the latched sum and carry vectors
// CHUNK bits per cycle through a single shared chunk adder.
// Optional feature macro: CSA_RESOLVER_COUT_EN adds the cout_o port
// (carry out of bit BITS-1, registered with the result).
module csa_resolver
    import csa_pkg::*;
#(
    parameter int BITS  = CSA_BITS,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [BITS-1:0] sum_i,
    input  logic [BITS-1:0] carry_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [BITS-1:0] result_o,
`ifdef CSA_RESOLVER_COUT_EN
    output logic            cout_o,
`endif
    output logic            busy_o
);

    localparam int N  = BITS / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    // Uneven chunking would leave a partial slice; refuse to build.
    if (BITS % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolver: BITS must be a multiple of CHUNK");
    end

    csa_state_e      state_q, state_d;
    logic [KW-1:0]   k_q;
    logic            rcarry_q;
    logic [BITS-1:0] sum_q;
    logic [BITS-1:0] carry_q;
    logic [BITS-1:0] result_q;
    logic            accept;
    logic            last_chunk;
    logic [CHUNK-1:0] add_sum;
    logic             add_cout;

    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign last_chunk  = (k_q == KW'(N - 1));
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == ADD);
    assign result_o    = result_q;

    csa_chunk_add #(.CHUNK(CHUNK)) u_add (
        .a_i    (sum_q[k_q*CHUNK +: CHUNK]),
        .b_i    (carry_q[k_q*CHUNK +: CHUNK]),
        .cin_i  (rcarry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Next-state: accept wins from IDLE/DONE; ADD runs until the last chunk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = ADD;
            ADD:  if (last_chunk) state_d = DONE;
            DONE: begin
                if (accept)           state_d = ADD;
                else if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath: latch operands on accept, then resolve one chunk per ADD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q      <= '0;
            rcarry_q <= 1'b0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            k_q      <= '0;
            rcarry_q <= 1'b0;
            sum_q    <= sum_i;
            carry_q  <= carry_i;
        end else if (state_q == ADD) begin
            result_q[k_q*CHUNK +: CHUNK] <= add_sum;
            rcarry_q <= add_cout;
            k_q      <= last_chunk ? '0 : k_q + KW'(1);
        end
    end

`ifdef CSA_RESOLVER_COUT_EN
    logic cout_q;

    // Final chunk carry becomes the visible carry out, alongside the result.
    always_ff @(posedge clk_i) begin
        if (rst_i)                             cout_q <= 1'b0;
        else if ((state_q == ADD) && last_chunk) cout_q <= add_cout;
    end

    assign cout_o = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Directed + randomised self-checking bench for csa_resolver.
module tb_csa_resolver;

    localparam int BITS = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] sum_v;
    logic [BITS-1:0] carry_v;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] result;
    logic            busy;
`ifdef CSA_RESOLVER_COUT_EN
    logic            cout;
`endif

    int total = 0;
    int bad   = 0;

    csa_resolver dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sum_i       (sum_v),
        .carry_i     (carry_v),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
`ifdef CSA_RESOLVER_COUT_EN
        .cout_o      (cout),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair from IDLE, return cycles from accept edge to out_valid.
    task automatic issue(input logic [BITS-1:0] s, input logic [BITS-1:0] c, output int lat);
        sum_v    = s;
        carry_v  = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [BITS-1:0] hold;
    logic [BITS:0]   wide;
    logic [BITS-1:0] a, b, c, s3, c3;
    int              lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_v = '0; carry_v = '0;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_result",    64'(result),    64'd0);
`ifdef CSA_RESOLVER_COUT_EN
        chk("rst_cout",      64'(cout),      64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Carry ripples across the chunk 0/1 boundary.
        sum_v = 48'h0000_0000_FFFF; carry_v = 48'h0000_0000_0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add_busy",     64'(busy),     64'd1);
        chk("add_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        chk("v1_latency", 64'(lat),    64'd3);
        chk("v1_result",  64'(result), 64'h0000_0001_0000);
`ifdef CSA_RESOLVER_COUT_EN
        chk("v1_cout",    64'(cout),   64'd0);
`endif
        consume();
        chk("v1_idle_valid", 64'(out_valid), 64'd0);

        // Full wrap: all-ones plus one.
        issue(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, lat);
        chk("v2_latency", 64'(lat),    64'd3);
        chk("v2_result",  64'(result), 64'h0);
`ifdef CSA_RESOLVER_COUT_EN
        chk("v2_cout",    64'(cout),   64'd1);
`endif
        consume();

        // 3:2 output of 1,2,3: sum=0, carry=6.
        issue(48'h0, 48'h6, lat);
        chk("v3_result", 64'(result), 64'h6);
        consume();

        // Backpressure in DONE, then back-to-back accept.
        issue(48'h1234_5678_9ABC, 48'h1111_1111_1111, lat);
        chk("v4_result", 64'(result), 64'h2345_6789_ABCD);
        hold = result;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_result",   64'(result),    64'(hold));
            chk("hold_in_ready", 64'(in_ready),  64'd0);
            chk("hold_valid",    64'(out_valid), 64'd1);
        end
        sum_v = 48'h8000_0000_0000; carry_v = 48'h8000_0000_0001;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy",  64'(busy),      64'd1);
        chk("b2b_valid", 64'(out_valid), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        chk("b2b_latency", 64'(lat),    64'd3);
        chk("b2b_result",  64'(result), 64'h1);
`ifdef CSA_RESOLVER_COUT_EN
        chk("b2b_cout",    64'(cout),   64'd1);
`endif
        consume();

        // Reset on the second ADD cycle discards the operation.
        sum_v = 48'h0000_FFFF_0000; carry_v = 48'h0000_0001_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_in_ready", 64'(in_ready),  64'd1);
        chk("rst_mid_busy",     64'(busy),      64'd0);
        chk("rst_mid_result",   64'(result),    64'd0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) lat++;
        end
        chk("rst_mid_no_result", 64'(lat), 64'd0);

        // Random 3:2 compressed operands with valid/ready stalls.
        for (int i = 0; i < 1000; i++) begin
            a = BITS'({$urandom, $urandom});
            b = BITS'({$urandom, $urandom});
            c = BITS'({$urandom, $urandom});
            s3 = a ^ b ^ c;
            c3 = ((a & b) | (a & c) | (b & c)) << 1;
            for (int d = $urandom_range(0, 2); d > 0; d--) step();
            issue(s3, c3, lat);
            if (lat >= 20) chk("rnd_timeout", 64'(lat), 64'd3);
            for (int d = $urandom_range(0, 2); d > 0; d--) step();
            wide = {1'b0, a} + {1'b0, b} + {1'b0, c};
            chk("rnd_result", 64'(result), 64'(wide[BITS-1:0]));
`ifdef CSA_RESOLVER_COUT_EN
            wide = {1'b0, s3} + {1'b0, c3};
            chk("rnd_cout", 64'(cout), 64'(wide[BITS]));
`endif
            consume();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 Parameter BITS, default 48, shall set the operand and result width.
REQ-002 Parameter CHUNK, default 16, shall set the bits resolved per cycle; BITS%CHUNK!=0 shall be an elaboration error.
REQ-003 clk_i  input  1  single clock; all state shall update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 in_valid_i  input  1  a carry-save operand pair is presented.
REQ-006 in_ready_o  output  1  the block accepts the pair this cycle.
REQ-007 sum_i  input  BITS  carry-save sum vector.
REQ-008 carry_i  input  BITS  carry-save carry vector, already left-aligned (bit 0 treated as an ordinary bit).
REQ-009 out_valid_o  output  1  result_o holds a resolved value.
REQ-010 out_ready_i  input  1  the consumer takes the result this cycle.
REQ-011 result_o  output  BITS  (sum_i+carry_i) mod 2^BITS.
REQ-012 cout_o  output  1  carry out of bit BITS-1 (present only under REQ-027).
REQ-013 busy_o  output  1  the FSM is in ADD.

Function
REQ-014 The FSM shall have the states IDLE, ADD and DONE, encoded as a 2-bit enum.
REQ-015 Accept = in_valid_i&&in_ready_o; in_ready_o=(IDLE)||(DONE&&out_ready_i).
REQ-016 On accept: latch sum_i and carry_i, clear the chunk index and the running carry to 0, and go to ADD.
REQ-017 ADD: each cycle add chunk k of both latched vectors plus the running carry, write result bits [k*CHUNK+:CHUNK], register the chunk carry-out and increment k.
REQ-018 ADD: after chunk N-1 (N=BITS/CHUNK) go to DONE, with out_valid_o=1 from the next cycle; latency from accept edge to out_valid_o is exactly N cycles (3 at defaults).
REQ-019 DONE: out_valid_o=1, and result_o/cout_o shall stay stable until out_ready_i=1.
REQ-020 DONE with out_ready_i=1 and no accept: go to IDLE and deassert out_valid_o.
REQ-021 DONE with out_ready_i=1 and an accept in the same cycle: go straight to ADD with the new operands (back-to-back, no bubble).
REQ-022 in_valid_i during ADD shall be ignored (in_ready_o=0); upstream holds its data.
REQ-023 Between results result_o shall only update chunk by chunk during ADD; its content is unspecified while out_valid_o=0.

Reset
REQ-024 On rst_i=1: state=IDLE, out_valid_o=0, busy_o=0, result_o=0, cout_o=0, chunk index=0, running carry=0, operand registers=0.
REQ-025 Reset during ADD or DONE shall discard the operation; in the cycle after reset in_ready_o=1 and no result is produced.
REQ-026 Reset shall take priority over any simultaneous accept or handshake.

Configuration
REQ-027 With CSA_RESOLVER_COUT_EN defined, cout_o shall exist and equal the final chunk carry, registered with the result.
REQ-028 Without CSA_RESOLVER_COUT_EN, cout_o shall be absent and the MSB carry discarded; all other behaviour shall be identical.

Structure
REQ-029 Package csa_pkg shall hold CSA_BITS=48, CSA_CHUNK=16, CSA_NCHUNK=CSA_BITS/CSA_CHUNK and the typedef csa_state_e (IDLE, ADD, DONE).
REQ-030 Combinational sub-module csa_chunk_add (CHUNK-bit a, b, cin -> sum, cout) shall be instantiated once and reused every ADD cycle.

Verification
REQ-031 sum=0x0000_0000_FFFF, carry=0x0000_0000_0001 -> result 0x0000_0001_0000, cout 0; out_valid exactly 3 cycles after accept.
REQ-032 sum=0xFFFF_FFFF_FFFF, carry=0x0000_0000_0001 -> result 0x0000_0000_0000, cout 1 (macro on; no cout_o port with the macro off).
REQ-033 3:2 output of a=1, b=2, c=3 (sum=0x0, carry=0x6) -> result 0x6.
REQ-034 Hold out_ready_i=0 for 5 cycles in DONE -> result stable, in_ready_o=0; then out_ready_i=1 with in_valid_i=1 -> new pair accepted that cycle, next out_valid 3 cycles later.
REQ-035 rst_i pulse on the 2nd ADD cycle -> out_valid_o stays 0, in_ready_o=1 the next cycle, and no stale result ever appears.
REQ-036 1000 random a, b, c through a reference 3:2 compressor -> result_o == (a+b+c) mod 2^48 with random valid/ready stalls.
